// File: rtl/sha_state_bank_if.sv
// Versat data/control bus between a master and the SHA state bank.
// Signals: valid/addr/wstrb/wdata (request), ready/rdata (single-cycle response).
interface sha_state_bank_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned A_W    = 4
);
  logic                  valid;
  logic [A_W-1:0]        addr;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     wdata;
  logic                  ready;
  logic [DATA_W-1:0]     rdata;

  modport master (output valid, addr, wstrb, wdata, input ready, rdata);
  modport slave  (input valid, addr, wstrb, wdata, output ready, rdata);
endinterface

// File: rtl/sha_state_bank.sv
// Bank of N_CH SHA state words. After a per-channel delay following run, each
// enabled channel loads or accumulates its datapath input; all state and config
// is memory-mapped on the Versat bus.
// Ports: clk, rst (async active-low), run (start pulse), done (all channels idle),
//        in/delay (per-channel packed inputs), out/currentValue (state words),
//        bus (slave side: valid/addr/wstrb/wdata -> ready/rdata).
module sha_state_bank #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned N_CH    = 8,
  parameter int unsigned DELAY_W = 32,
  parameter int unsigned A_W     = $clog2(N_CH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  output logic                    done,
  input  logic [N_CH*DATA_W-1:0]  in,
  input  logic [N_CH*DELAY_W-1:0] delay,
  output logic [N_CH*DATA_W-1:0]  out,
  output logic [N_CH*DATA_W-1:0]  currentValue,
  sha_state_bank_if.slave         bus
);

  localparam int unsigned NB = DATA_W / 8;

  typedef enum logic {ST_IDLE, ST_WAIT} ch_state_e;

  ch_state_e          st_q   [N_CH];
  ch_state_e          st_d   [N_CH];
  logic [DELAY_W-1:0] cnt_q  [N_CH];
  logic [DELAY_W-1:0] cnt_d  [N_CH];
  logic [DATA_W-1:0]  word_q [N_CH];
  logic [DATA_W-1:0]  word_d [N_CH];

  logic [N_CH-1:0]    mode_q, mode_d;
  logic [N_CH-1:0]    en_q, en_d;
  logic [N_CH-1:0]    busy_c;
  logic [N_CH-1:0]    cap_c;
  logic               done_q, done_d;
  logic               ready_q;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic               is_ctrl_c;
  logic               wr_c;
  logic [31:0]        low_c;

  // Byte-strobed merge of write data into an existing word.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [NB-1:0]     strb
  );
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < int'(NB); b++) begin
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  // Address decode: top bit selects control space, remaining bits the index.
  always_comb begin
    is_ctrl_c = bus.addr[A_W-1];
    low_c     = 32'(bus.addr) & ~(32'd1 << (A_W - 1));
    wr_c      = bus.valid && (bus.wstrb != '0);
  end

  // Per-channel delay FSMs, capture and state-word bus writes.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      st_d[k]   = st_q[k];
      cnt_d[k]  = cnt_q[k];
      word_d[k] = word_q[k];
      cap_c[k]  = 1'b0;
      busy_c[k] = (st_q[k] == ST_WAIT);

      case (st_q[k])
        ST_IDLE: begin
          if (run && en_q[k]) begin
            st_d[k]  = ST_WAIT;
            cnt_d[k] = delay[k*DELAY_W +: DELAY_W];
          end
        end
        ST_WAIT: begin
          // A new run restarts the countdown and suppresses this cycle's capture.
          if (run && en_q[k]) begin
            cnt_d[k] = delay[k*DELAY_W +: DELAY_W];
          end else if (cnt_q[k] == '0) begin
            cap_c[k] = 1'b1;
            st_d[k]  = ST_IDLE;
          end else begin
            cnt_d[k] = cnt_q[k] - DELAY_W'(1);
          end
        end
        default: st_d[k] = ST_IDLE;
      endcase

      // Capture beats a simultaneous bus write to the same word.
      if (cap_c[k]) begin
        word_d[k] = mode_q[k] ? (word_q[k] + in[k*DATA_W +: DATA_W])
                              : in[k*DATA_W +: DATA_W];
      end else if (wr_c && !is_ctrl_c && (low_c == 32'(k))) begin
        word_d[k] = merge_bytes(word_q[k], bus.wdata, bus.wstrb);
      end
    end

    done_d = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      if (st_d[k] != ST_IDLE) done_d = 1'b0;
    end
  end

  // Bus read mux and MODE/ENABLE writes.
  always_comb begin
    mode_d  = mode_q;
    en_d    = en_q;
    rdata_d = '0;

    if (bus.valid) begin
      if (!is_ctrl_c) begin
        for (int k = 0; k < N_CH; k++) begin
          if (low_c == 32'(k)) rdata_d = word_q[k];
        end
      end else begin
        case (low_c)
          32'd0:   rdata_d = DATA_W'(mode_q);
          32'd1:   rdata_d = DATA_W'(en_q);
          32'd2:   rdata_d = DATA_W'(busy_c);
          default: rdata_d = '0;
        endcase
      end
    end

    if (wr_c && is_ctrl_c) begin
      if (low_c == 32'd0) mode_d = N_CH'(merge_bytes(DATA_W'(mode_q), bus.wdata, bus.wstrb));
      if (low_c == 32'd1) en_d   = N_CH'(merge_bytes(DATA_W'(en_q), bus.wdata, bus.wstrb));
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_CH; k++) begin
        st_q[k]   <= ST_IDLE;
        cnt_q[k]  <= '0;
        word_q[k] <= '0;
      end
      mode_q  <= '0;
      en_q    <= '1;
      done_q  <= 1'b1;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        st_q[k]   <= st_d[k];
        cnt_q[k]  <= cnt_d[k];
        word_q[k] <= word_d[k];
      end
      mode_q  <= mode_d;
      en_q    <= en_d;
      done_q  <= done_d;
      ready_q <= bus.valid;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are driven straight from flops.
  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign out[g*DATA_W +: DATA_W]          = word_q[g];
    assign currentValue[g*DATA_W +: DATA_W] = word_q[g];
  end

  assign done      = done_q;
  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_sha_state_bank.sv
// Self-checking bench for sha_state_bank (N_CH=8, DATA_W=32): directed scenarios
// with literal expectations plus a randomized phase, all outputs compared every
// cycle against a cycle-scheduled behavioural model.
module tb_sha_state_bank;

  localparam int unsigned DW = 32;
  localparam int unsigned NC = 8;
  localparam int unsigned AW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             run = 1'b0;
  logic             done;
  logic [NC*DW-1:0] in_v  = '0;
  logic [NC*DW-1:0] dly_v = '0;
  logic [NC*DW-1:0] out_v;
  logic [NC*DW-1:0] cv_v;

  sha_state_bank_if #(.DATA_W(DW), .A_W(AW)) bus_if ();

  sha_state_bank #(.DATA_W(DW), .N_CH(NC), .DELAY_W(DW), .A_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .done         (done),
    .in           (in_v),
    .delay        (dly_v),
    .out          (out_v),
    .currentValue (cv_v),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  // Behavioural model: each armed channel holds the absolute edge number it captures at.
  logic [31:0] m_word [NC];
  logic [7:0]  m_mode, m_en;
  bit          m_pend [NC];
  longint      m_due  [NC];
  longint      cyc = 0;
  logic        m_ready;
  logic [31:0] m_rdata;

  function automatic logic [31:0] m_read(logic [3:0] a);
    logic [7:0] busy;
    for (int k = 0; k < NC; k++) busy[k] = m_pend[k];
    if (a < 4'd8) return m_word[a[2:0]];
    case (a)
      4'd8:    return {24'd0, m_mode};
      4'd9:    return {24'd0, m_en};
      4'd10:   return {24'd0, busy};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin : model
    logic       wr;
    logic [7:0] nmode, nen;
    bit         capd;
    if (!rst) begin
      for (int k = 0; k < NC; k++) begin
        m_word[k] = '0; m_pend[k] = 1'b0; m_due[k] = 0;
      end
      m_mode = 8'h00; m_en = 8'hFF; m_ready = 1'b0; m_rdata = '0;
    end else begin
      cyc++;
      m_ready = bus_if.valid;
      m_rdata = bus_if.valid ? m_read(bus_if.addr) : 32'd0;
      wr    = bus_if.valid && (bus_if.wstrb != 4'd0);
      nmode = m_mode;
      nen   = m_en;
      for (int k = 0; k < NC; k++) begin
        capd = 1'b0;
        if (run && m_en[k]) begin
          m_pend[k] = 1'b1;
          m_due[k]  = cyc + 1 + longint'(dly_v[k*DW +: DW]);
        end else if (m_pend[k] && m_due[k] == cyc) begin
          capd      = 1'b1;
          m_pend[k] = 1'b0;
          m_word[k] = m_mode[k] ? m_word[k] + in_v[k*DW +: DW] : in_v[k*DW +: DW];
        end
        if (!capd && wr && bus_if.addr == 4'(k))
          m_word[k] = merge(m_word[k], bus_if.wdata, bus_if.wstrb);
      end
      if (wr && bus_if.addr == 4'd8) nmode = merge({24'd0, m_mode}, bus_if.wdata, bus_if.wstrb) & 32'hFF;
      if (wr && bus_if.addr == 4'd9) nen   = merge({24'd0, m_en}, bus_if.wdata, bus_if.wstrb) & 32'hFF;
      m_mode = nmode;
      m_en   = nen;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic m_done;
      m_done = 1'b1;
      for (int k = 0; k < NC; k++) begin
        if (m_pend[k]) m_done = 1'b0;
        chk($sformatf("out%0d", k), out_v[k*DW +: DW], m_word[k]);
        chk($sformatf("cv%0d", k), cv_v[k*DW +: DW], m_word[k]);
      end
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("ready", {31'd0, bus_if.ready}, {31'd0, m_ready});
      chk("rdata", bus_if.rdata, m_rdata);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_op(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] rd);
    bus_if.valid = 1'b1; bus_if.addr = a; bus_if.wstrb = s; bus_if.wdata = d;
    tick();
    bus_if.valid = 1'b0; bus_if.wstrb = 4'd0;
    rd = bus_if.rdata;
  endtask

  task automatic pulse_run();
    run = 1'b1; tick(); run = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    bus_if.valid = 1'b0; bus_if.addr = '0; bus_if.wstrb = '0; bus_if.wdata = '0;
    #3 rst = 1'b0;
    #1 chk_en = 1'b1;
    tick(2);
    rst = 1'b1;

    // Reset values and readback.
    chk("rst_done", {31'd0, done}, 32'd1);
    chk("rst_ready", {31'd0, bus_if.ready}, 32'd0);
    chk("rst_rdata", bus_if.rdata, 32'd0);
    for (int a = 0; a < 8; a++) begin
      bus_op(4'(a), 4'd0, 32'd0, rd);
      chk($sformatf("rst_state%0d", a), rd, 32'd0);
    end
    bus_op(4'd9, 4'd0, 32'd0, rd); chk("rst_enable", rd, 32'hFF);
    bus_op(4'd8, 4'd0, 32'd0, rd); chk("rst_mode", rd, 32'h00);
    tick();
    chk("idle_rdata", bus_if.rdata, 32'd0);

    // Load mode, delay k on channel k.
    for (int k = 0; k < NC; k++) begin
      in_v[k*DW +: DW]  = 32'h1000 + 32'(k);
      dly_v[k*DW +: DW] = 32'(k);
    end
    pulse_run();
    for (int i = 1; i <= 8; i++) begin
      tick();
      for (int k = 0; k < NC; k++)
        chk($sformatf("load_t%0d_ch%0d", i, k), out_v[k*DW +: DW],
            (k < i) ? 32'h1000 + 32'(k) : 32'd0);
      chk($sformatf("load_done_t%0d", i), {31'd0, done}, (i >= 8) ? 32'd1 : 32'd0);
    end

    // Accumulate with carry dropped.
    dly_v = '0;
    bus_op(4'd0, 4'hF, 32'hFFFF_FFFF, rd);
    bus_op(4'd8, 4'h1, 32'h0000_0001, rd);
    in_v[0 +: DW] = 32'd2;
    pulse_run(); tick();
    chk("acc_first", out_v[0 +: DW], 32'h0000_0001);
    pulse_run(); tick();
    chk("acc_second", out_v[0 +: DW], 32'h0000_0003);

    // Restart and capture/write collision on channel 3.
    in_v[0 +: DW]      = 32'd0;
    in_v[3*DW +: DW]   = 32'h3333;
    dly_v[3*DW +: DW]  = 32'd5;
    pulse_run();
    tick(2);
    pulse_run();
    tick(2);
    chk("restart_no_cap_t6", out_v[3*DW +: DW], 32'h1003);
    tick(3);
    chk("restart_no_cap_t8", out_v[3*DW +: DW], 32'h1003);
    bus_op(4'd3, 4'hF, 32'hDEAD_BEEF, rd);
    chk("collide_ready", {31'd0, bus_if.ready}, 32'd1);
    chk("collide_capture", out_v[3*DW +: DW], 32'h3333);

    // Disabled channel 0 and byte-strobed write.
    dly_v = '0;
    in_v[0 +: DW] = 32'h55;
    bus_op(4'd9, 4'hF, 32'hFE, rd);
    run = 1'b1; tick(); run = 1'b0;
    bus_op(4'd10, 4'd0, 32'd0, rd);
    chk("dis_status_bit0", rd & 32'h1, 32'd0);
    tick(8);
    chk("dis_ch0_unchanged", out_v[0 +: DW], 32'h0000_0003);
    bus_op(4'd1, 4'hF, 32'd0, rd);
    bus_op(4'd1, 4'b0010, 32'hAABB_CCDD, rd);
    bus_op(4'd1, 4'd0, 32'd0, rd);
    chk("byte_write", rd, 32'h0000_CC00);

    // Reset in the middle of a long wait.
    bus_op(4'd9, 4'hF, 32'hFF, rd);
    dly_v[2*DW +: DW] = 32'd10;
    pulse_run();
    tick(3);
    rst = 1'b0;
    #1;
    chk("rst_mid_out2", out_v[2*DW +: DW], 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd1);
    tick();
    rst = 1'b1;
    tick(15);
    chk("rst_mid_nocap", out_v[2*DW +: DW], 32'd0);
    chk("rst_mid_done2", {31'd0, done}, 32'd1);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      run = ($urandom_range(0, 7) == 0);
      if (run) begin
        for (int k = 0; k < NC; k++) begin
          dly_v[k*DW +: DW] = 32'($urandom_range(0, 6));
          in_v[k*DW +: DW]  = $urandom;
        end
      end
      bus_if.valid = ($urandom_range(0, 2) != 0);
      bus_if.addr  = 4'($urandom_range(0, 15));
      bus_if.wstrb = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bus_if.wdata = $urandom;
      tick();
    end
    run = 1'b0; bus_if.valid = 1'b0; bus_if.wstrb = 4'd0;
    tick(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
